noc_bridge_axis_serializer: RTL and testbench

NOC_BRIDGE_AXIS_SERIALIZER -- requirements
Module: noc_bridge_axis_serializer

---
 rtl/noc_bridge_pkg.sv | 24 ++
 rtl/noc_bridge_axis_serializer.sv | 108 ++++++++++
 tb/tb_noc_bridge_axis_serializer.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/noc_bridge_pkg.sv
// Shared NoC bridge types and constants for the AXIS width converters.
package noc_bridge_pkg;

  localparam int unsigned BridgeUserWidth   = 8;
  localparam int unsigned ChunkWidthDefault = 16;

  typedef logic [BridgeUserWidth-1:0] bridge_user_t;

  typedef enum logic {
    SER_IDLE = 1'b0,
    SER_SEND = 1'b1
  } ser_state_e;

  function automatic int unsigned num_chunks(input int unsigned payload_width,
                                             input int unsigned chunk_width);
    return (payload_width + chunk_width - 1) / chunk_width;
  endfunction

  // Never zero, so a single-chunk configuration still gets a real counter bit.
  function automatic int unsigned chunk_cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/noc_bridge_axis_serializer.sv
// Splits each wide bridge beat {tuser, tdata} into ChunkWidth link chunks, LSB chunk first.
//   state    | meaning
//   SER_IDLE | no beat held, ready for a new wide beat
//   SER_SEND | beat held in payload_q, cnt_q selects the chunk on the link
module noc_bridge_axis_serializer
  import noc_bridge_pkg::*;
#(
  parameter int unsigned DataWidth    = 72,
  parameter int unsigned UserWidth    = BridgeUserWidth,
  parameter int unsigned ChunkWidth   = ChunkWidthDefault,
  parameter bit          IgnoreAssert = 1'b0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DataWidth-1:0]  s_tdata_i,
  input  logic [UserWidth-1:0]  s_tuser_i,
  input  logic                  s_tvalid_i,
  output logic                  s_tready_o,
  output logic [ChunkWidth-1:0] m_tdata_o,
  output logic                  m_tlast_o,
  output logic                  m_tvalid_o,
  input  logic                  m_tready_i
);

  localparam int unsigned PayloadWidth = DataWidth + UserWidth;
  localparam int unsigned NumChunks    = num_chunks(PayloadWidth, ChunkWidth);
  localparam int unsigned PaddedWidth  = NumChunks * ChunkWidth;
  localparam int unsigned CntWidth     = chunk_cnt_width(NumChunks);
  localparam logic [CntWidth-1:0] LastIdx = CntWidth'(NumChunks - 1);

  ser_state_e                           state_q, state_d;
  logic [CntWidth-1:0]                  cnt_q, cnt_d;
  logic [NumChunks-1:0][ChunkWidth-1:0] payload_q, payload_d;
  logic [PaddedWidth-1:0]               load_payload;
  logic                                 beat_hs;
  logic                                 chunk_hs;

  always_comb begin
    load_payload                     = '0;
    load_payload[PayloadWidth-1:0]   = {s_tuser_i, s_tdata_i};
  end

  assign beat_hs  = s_tvalid_i & s_tready_o;
  assign chunk_hs = m_tvalid_o & m_tready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= SER_IDLE;
      cnt_q     <= '0;
      payload_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      payload_q <= payload_d;
    end
  end

  // A new beat always wins over the last-chunk retire, which gives back-to-back beats.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    payload_d = payload_q;
    if (beat_hs) begin
      state_d   = SER_SEND;
      cnt_d     = '0;
      payload_d = load_payload;
    end else if (chunk_hs) begin
      if (m_tlast_o) begin
        state_d = SER_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d   = cnt_q + CntWidth'(1);
      end
    end
  end

  // Wide ready is gated by rst_ni so nothing is accepted while reset is held.
  always_comb begin
    s_tready_o = 1'b0;
    m_tvalid_o = 1'b0;
    m_tlast_o  = 1'b0;
    m_tdata_o  = '0;
    unique case (state_q)
      SER_IDLE: begin
        s_tready_o = rst_ni;
      end
      SER_SEND: begin
        m_tvalid_o = 1'b1;
        m_tlast_o  = (cnt_q == LastIdx);
        m_tdata_o  = payload_q[cnt_q];
        s_tready_o = rst_ni & m_tlast_o & m_tready_i;
      end
      default: ;
    endcase
  end

  if (!IgnoreAssert) begin : g_assert
    a_chunk_width: assert property (@(posedge clk_i) ChunkWidth > 0);

    a_m_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (m_tvalid_o && !m_tready_i) |=>
        (m_tvalid_o && $stable(m_tdata_o) && $stable(m_tlast_o)));

    a_cnt_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
      cnt_q <= LastIdx);
  end

endmodule

// File: tb/tb_noc_bridge_axis_serializer.sv
// Scoreboard bench for the AXIS serializer: default 5-chunk config plus a single-chunk config.
module tb_noc_bridge_axis_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [71:0] s_tdata;
  logic [7:0]  s_tuser;
  logic        s_tvalid;
  logic        s_tready;
  logic [15:0] m_tdata;
  logic        m_tlast;
  logic        m_tvalid;
  logic        m_tready;

  logic [7:0]  s1_tdata;
  logic [7:0]  s1_tuser;
  logic        s1_tvalid;
  logic        s1_tready;
  logic [15:0] m1_tdata;
  logic        m1_tlast;
  logic        m1_tvalid;
  logic        m1_tready;

  always #5 clk = ~clk;

  noc_bridge_axis_serializer #(
    .DataWidth(72), .UserWidth(8), .ChunkWidth(16), .IgnoreAssert(1'b0)
  ) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .s_tdata_i(s_tdata), .s_tuser_i(s_tuser), .s_tvalid_i(s_tvalid), .s_tready_o(s_tready),
    .m_tdata_o(m_tdata), .m_tlast_o(m_tlast), .m_tvalid_o(m_tvalid), .m_tready_i(m_tready)
  );

  noc_bridge_axis_serializer #(
    .DataWidth(8), .UserWidth(8), .ChunkWidth(16), .IgnoreAssert(1'b0)
  ) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n),
    .s_tdata_i(s1_tdata), .s_tuser_i(s1_tuser), .s_tvalid_i(s1_tvalid), .s_tready_o(s1_tready),
    .m_tdata_o(m1_tdata), .m_tlast_o(m1_tlast), .m_tvalid_o(m1_tvalid), .m_tready_i(m1_tready)
  );

  logic [16:0] exp_q[$];
  logic [16:0] exp1_q[$];
  int          hs_cyc_q[$];
  int          checks = 0;
  int          errors = 0;
  int          n_popped = 0;
  int          n1_popped = 0;
  int          stall_cnt = 0;
  int          cyc = 0;
  logic        held_v = 1'b0;
  logic [16:0] held;
  logic [16:0] e;
  logic [16:0] e1;

  // Monitor for the 5-chunk instance: scoreboard pop, hold stability, wide-ready rule.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      held_v = 1'b0;
    end else begin
      checks++;
      if (s_tready !== (m_tvalid ? (m_tlast & m_tready) : 1'b1)) begin
        errors++;
        $display("FAIL s_tready cyc=%0d actual=%b required=%b", cyc, s_tready,
                 (m_tvalid ? (m_tlast & m_tready) : 1'b1));
      end
      if (held_v) begin
        checks++;
        if (!m_tvalid || {m_tlast, m_tdata} !== held) begin
          errors++;
          $display("FAIL stall_stable cyc=%0d actual=%b/%h required=1/%h", cyc, m_tvalid,
                   {m_tlast, m_tdata}, held);
        end
      end
      if (m_tvalid && m_tready) begin
        hs_cyc_q.push_back(cyc);
        n_popped++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL chunk_unexpected cyc=%0d actual=%h required=none", cyc, {m_tlast, m_tdata});
        end else begin
          e = exp_q.pop_front();
          if ({m_tlast, m_tdata} !== e) begin
            errors++;
            $display("FAIL chunk cyc=%0d actual={last %b,%h} required={last %b,%h}", cyc,
                     m_tlast, m_tdata, e[16], e[15:0]);
          end
        end
      end
      if (m_tvalid && !m_tready) stall_cnt++;
      held_v = m_tvalid && !m_tready;
      held   = {m_tlast, m_tdata};
    end
  end

  always @(negedge clk) begin
    if (rst_n && m1_tvalid && m1_tready) begin
      n1_popped++;
      checks++;
      if (exp1_q.size() == 0) begin
        errors++;
        $display("FAIL chunk1_unexpected actual=%h required=none", {m1_tlast, m1_tdata});
      end else begin
        e1 = exp1_q.pop_front();
        if ({m1_tlast, m1_tdata} !== e1) begin
          errors++;
          $display("FAIL chunk1 actual={last %b,%h} required={last %b,%h}", m1_tlast, m1_tdata,
                   e1[16], e1[15:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_beat(input logic [71:0] d, input logic [7:0] u);
    logic [79:0] p;
    p = {u, d};
    for (int k = 0; k < 5; k++) exp_q.push_back({(k == 4), p[k*16 +: 16]});
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic send_beat(input logic [71:0] d, input logic [7:0] u, input bit auto_push);
    int n;
    n = 0;
    s_tdata  = d;
    s_tuser  = u;
    s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_tready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!s_tready) begin
      errors++;
      $display("FAIL beat_accept timeout actual=no_ready required=ready data=%h", d);
    end else if (auto_push) begin
      push_beat(d, u);
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp1_q.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || exp1_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d/%0d left required=0/0", exp_q.size(), exp1_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pops(input int target);
    int n;
    n = 0;
    while (n_popped < target && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("wait_pops", 32'(n_popped), 32'(target));
  endtask

  typedef struct {
    logic [7:0]  d;
    logic [7:0]  u;
    logic [15:0] c;
  } one_vec_t;

  one_vec_t one_tbl[3] = '{
    '{8'h3C, 8'hC3, 16'hC33C},
    '{8'h5A, 8'hA5, 16'hA55A},
    '{8'hFF, 8'h00, 16'h00FF}
  };

  bit rnd_done;

  initial begin
    int h0, s0, base;
    logic [31:0] r0, r1, r2;
    rst_n = 1'b0;
    s_tdata = '0; s_tuser = '0; s_tvalid = 1'b0; m_tready = 1'b1;
    s1_tdata = '0; s1_tuser = '0; s1_tvalid = 1'b0; m1_tready = 1'b1;
    rnd_done = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_tready", 32'(s_tready), 32'd0);
    chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_m_tlast", 32'(m_tlast), 32'd0);
    chk("rst_m_tdata", 32'(m_tdata), 32'd0);
    chk("rst_s1_tready", 32'(s1_tready), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_s_tready", 32'(s_tready), 32'd1);
    chk("post_rst_s1_tready", 32'(s1_tready), 32'd1);
    @(posedge clk);
    #1;

    // Single beat with hand-split chunks, first chunk one cycle after accept.
    exp_q.push_back({1'b0, 16'h8899});
    exp_q.push_back({1'b0, 16'h6677});
    exp_q.push_back({1'b0, 16'h4455});
    exp_q.push_back({1'b0, 16'h2233});
    exp_q.push_back({1'b1, 16'hA511});
    send_beat(72'h11_2233_4455_6677_8899, 8'hA5, 1'b0);
    @(negedge clk);
    chk("latency1_valid", 32'(m_tvalid), 32'd1);
    chk("latency1_data", 32'(m_tdata), 32'h8899);
    wait_drain();

    // Three beats back to back with valid held.
    h0 = hs_cyc_q.size();
    send_beat(72'h01_0203_0405_0607_0809, 8'h10, 1'b1);
    send_beat(72'hFE_DCBA_9876_5432_10FF, 8'h5C, 1'b1);
    send_beat(72'h00_0000_0000_0000_0001, 8'h80, 1'b1);
    wait_drain();
    chk("b2b_chunks", 32'(hs_cyc_q.size() - h0), 32'd15);
    if (hs_cyc_q.size() - h0 >= 15)
      chk("b2b_span", 32'(hs_cyc_q[h0+14] - hs_cyc_q[h0]), 32'd14);

    // Backpressure on chunk 2 for four cycles.
    base = n_popped;
    s0   = stall_cnt;
    send_beat(72'hAB_CDEF_0123_4567_89AB, 8'h3E, 1'b1);
    wait_pops(base + 2);
    @(posedge clk);
    #1;
    m_tready = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    m_tready = 1'b1;
    wait_drain();
    chk("bp_stall_cycles", 32'(stall_cnt - s0), 32'd4);
    chk("bp_chunks", 32'(n_popped - base), 32'd5);

    // Reset after chunk 1 accepted; the rest of that beat must vanish.
    base = n_popped;
    send_beat(72'h77_6655_4433_2211_0099, 8'h42, 1'b1);
    wait_pops(base + 2);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_m_tvalid", 32'(m_tvalid), 32'd0);
    chk("midrst_s_tready", 32'(s_tready), 32'd0);
    chk("midrst_m_tdata", 32'(m_tdata), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_release_ready", 32'(s_tready), 32'd1);
    chk("midrst_release_valid", 32'(m_tvalid), 32'd0);
    @(posedge clk);
    #1;
    base = n_popped;
    send_beat(72'h12_3456_789A_BCDE_F012, 8'h9D, 1'b1);
    wait_drain();
    chk("midrst_next_chunks", 32'(n_popped - base), 32'd5);

    // Single-chunk configuration: one beat per cycle.
    for (int i = 0; i < 3; i++) begin
      s1_tdata  = one_tbl[i].d;
      s1_tuser  = one_tbl[i].u;
      s1_tvalid = 1'b1;
      @(negedge clk);
      chk("one_s1_tready", 32'(s1_tready), 32'd1);
      exp1_q.push_back({1'b1, one_tbl[i].c});
      @(posedge clk);
      #1;
    end
    s1_tvalid = 1'b0;
    @(negedge clk);
    #1;
    chk("one_per_cycle", 32'(n1_popped), 32'd3);
    wait_drain();

    // Random valid gaps and ready pattern, 1000 beats.
    base = n_popped;
    fork
      begin
        for (int b = 0; b < 1000; b++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
          r0 = $urandom;
          r1 = $urandom;
          r2 = $urandom;
          send_beat({r2[7:0], r1, r0}, r2[15:8], 1'b1);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          m_tready = ($urandom_range(0, 3) != 0);
        end
        m_tready = 1'b1;
      end
    join
    wait_drain();
    chk("rand_chunks", 32'(n_popped - base), 32'd5000);

    chk("final_exp_q", 32'(exp_q.size()), 32'd0);
    chk("final_exp1_q", 32'(exp1_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
